// File: rtl/mole_scheduler.sv
// Whack-a-mole spawn/age/hit scheduler for four moles.
// Optional feature: define MISS_PENALTY_EN to deduct one point per button edge on an
// unlit mole (saturating at 0). Without the macro such edges are ignored.
module mole_scheduler #(
  parameter int unsigned LIFETIME   = 3,
  parameter int unsigned MAX_ACTIVE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        tick,
  input  logic [7:0]  rnd,
  input  logic [3:0]  button,
  output logic [3:0]  color,
  output logic [11:0] score_bcd,
  output logic        hit_pulse,
  output logic        miss_pulse
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [3:0]      color_q, color_d;
  logic [3:0][3:0] life_q, life_d;
  logic [11:0]     score_q, score_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic [3:0]      btn_q;

  logic [3:0] btn_edge;
  logic [3:0] hit;
  logic [3:0] after_hit;
  logic [3:0] expire;
  logic [3:0] alive;
  logic [1:0] cand;
  logic       active;
  logic       spawn;

  // Only the low two bits pick a spawn candidate.
  logic unused_rnd;
  assign unused_rnd = ^rnd[7:2];

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // BCD add of 0..4 with per-digit carry, saturating at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [2:0] n);
    logic [4:0] d0, d1, d2;
    logic       c0, c1;
    d0 = {1'b0, s[3:0]} + {2'b00, n};
    c0 = (d0 > 5'd9);
    if (c0) d0 = d0 - 5'd10;
    d1 = {1'b0, s[7:4]} + {4'b0000, c0};
    c1 = (d1 > 5'd9);
    if (c1) d1 = d1 - 5'd10;
    d2 = {1'b0, s[11:8]} + {4'b0000, c1};
    if (d2 > 5'd9) return 12'h999;
    return {d2[3:0], d1[3:0], d0[3:0]};
  endfunction

`ifdef MISS_PENALTY_EN
  // BCD subtract of 0..4 with per-digit borrow, saturating at 000.
  function automatic logic [11:0] bcd_sub(input logic [11:0] s, input logic [2:0] n);
    logic [3:0] d0, d1, d2;
    logic       b0, b1;
    b0 = (s[3:0] < {1'b0, n});
    d0 = b0 ? (s[3:0] + 4'd10 - {1'b0, n}) : (s[3:0] - {1'b0, n});
    b1 = (s[7:4] < {3'b000, b0});
    d1 = b1 ? 4'd9 : (s[7:4] - {3'b000, b0});
    if (s[11:8] < {3'b000, b1}) return 12'h000;
    d2 = s[11:8] - {3'b000, b1};
    return {d2, d1, d0};
  endfunction
`endif

  // Hit / expiry / spawn decisions for the current cycle.
  always_comb begin
    active    = (state_q == StRun) && run;
    btn_edge  = button & ~btn_q;
    hit       = active ? (btn_edge & color_q) : 4'b0000;
    after_hit = color_q & ~hit;
    expire    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      expire[i] = active && tick && after_hit[i] && (life_q[i] == 4'd1);
    end
    alive = after_hit & ~expire;
    cand  = rnd[1:0];
    // Slot count uses post-clear occupancy so an expiry can free room on the same tick.
    spawn = active && tick && !color_q[cand] && (popcount4(alive) < 3'(MAX_ACTIVE));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StRun;
      StRun:   if (!run) state_d = StFlush;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and life counters.
  always_comb begin
    color_d = color_q;
    life_d  = life_q;
    score_d = score_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        color_d = 4'b0000;
        life_d  = '0;
        if (run) score_d = 12'h000;
      end
      StRun: begin
        if (!run) begin
          color_d = 4'b0000;
          life_d  = '0;
        end else begin
          color_d = alive;
          for (int i = 0; i < 4; i++) begin
            if (!alive[i])  life_d[i] = 4'd0;
            else if (tick)  life_d[i] = life_q[i] - 4'd1;
            else            life_d[i] = life_q[i];
          end
          if (spawn) begin
            color_d[cand] = 1'b1;
            life_d[cand]  = 4'(LIFETIME);
          end
          hit_d   = |hit;
          miss_d  = |expire;
          score_d = bcd_add(score_q, popcount4(hit));
`ifdef MISS_PENALTY_EN
          score_d = bcd_sub(score_d, popcount4(btn_edge & ~color_q));
`endif
        end
      end
      StFlush: begin
        color_d = 4'b0000;
        life_d  = '0;
      end
      default: begin
        color_d = 4'b0000;
        life_d  = '0;
      end
    endcase
  end

  // State and output registers; btn_q tracks the buttons in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      color_q <= 4'b0000;
      life_q  <= '0;
      score_q <= 12'h000;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      btn_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      life_q  <= life_d;
      score_q <= score_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      btn_q   <= button;
    end
  end

  assign color      = color_q;
  assign score_bcd  = score_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter LIFETIME, default 3: number of tick pulses a lit mole stays up (1..15).
REQ-002 SHALL have parameter MAX_ACTIVE, default 2: maximum number of moles lit at once (1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port run  input  1  round active level from game FSM.
REQ-006 SHALL have port tick  input  1  one-cycle spawn/age strobe.
REQ-007 SHALL have port rnd  input  8  random byte from LFSR; rnd[1:0] selects spawn candidate.
REQ-008 SHALL have port button  input  4  debounced, synchronized buttons, active-high, one per mole.
REQ-009 SHALL have port color  output  4  mole lamps, bit i = mole i lit.
REQ-010 SHALL have port score_bcd  output  12  3-digit BCD score, [11:8] hundreds.
REQ-011 SHALL have port hit_pulse  output  1  one-cycle pulse, at least one hit this cycle.
REQ-012 SHALL have port miss_pulse  output  1  one-cycle pulse, at least one mole expired this cycle.

Function
REQ-013 SHALL implement states IDLE, RUN, FLUSH; all outputs registered.
REQ-014 IDLE: color=0; on run=1 -> RUN, score_bcd cleared to 0 and life counters cleared on that edge.
REQ-015 RUN: run=0 -> FLUSH; FLUSH: color=0, life counters cleared, -> IDLE next cycle unconditionally; score_bcd held.
REQ-016 Button edge SHALL be button[i] & ~btn_q[i], btn_q registered every cycle in all states; level-held buttons produce one edge only.
REQ-017 In RUN, edge on lit mole i SHALL clear color[i] and its life counter on the same clock edge the edge is sampled (visible next cycle); hit_pulse=1 that cycle.
REQ-018 Score SHALL add the number of hit moles in the cycle (0..4) in BCD with digit carries; saturate at 999.
REQ-019 On tick in RUN, each lit mole's life counter SHALL decrement; a mole reaching 0 is cleared and miss_pulse=1.
REQ-020 Same cycle hit and expiry on one mole: hit wins, no miss counted for it.
REQ-021 On tick in RUN, mole k=rnd[1:0] SHALL be lit with life=LIFETIME if it was unlit, not hit this cycle, and lit count after this cycle's clears < MAX_ACTIVE; otherwise no spawn (no retry).
REQ-022 Expiry freeing a slot on a tick SHALL permit spawn on the same tick.
REQ-023 tick, button and rnd SHALL be ignored outside RUN (btn_q still updates).
REQ-024 hit_pulse and miss_pulse SHALL be 0 in IDLE and FLUSH.

Reset
REQ-025 rst SHALL override all inputs: state=IDLE, color=0, score_bcd=0, hit_pulse=0, miss_pulse=0, btn_q=0, life counters=0.
REQ-026 rst asserted mid-RUN SHALL clear lit moles and score on that edge; no pulse emitted.

Configuration
REQ-027 Macro MISS_PENALTY_EN defined: in RUN, edges on unlit moles SHALL decrement score by the count of such edges, saturating at 0, applied after hits in the same cycle.
REQ-028 MISS_PENALTY_EN undefined: edges on unlit moles SHALL have no effect; penalty logic absent.

Verification
REQ-029 Reset then run=1, tick with rnd=8'h02 -> color=4'b0100 next cycle, score_bcd=12'h000.
REQ-030 Mole 2 lit, button=4'b0100 one cycle -> color=0, hit_pulse=1 one cycle, score_bcd=12'h001; button held 5 cycles adds nothing more.
REQ-031 LIFETIME=3, mole 0 lit, three ticks with rnd selecting lit mole 0 -> mole 0 cleared on third tick, miss_pulse=1; hit and third tick same cycle -> score+1, miss_pulse=0.
REQ-032 MAX_ACTIVE=2, moles 0,1 lit, tick rnd=8'h03 -> no spawn; score 12'h999 plus hit -> stays 12'h999; score 12'h009 plus hit -> 12'h010.
REQ-033 MISS_PENALTY_EN defined, score 12'h010, edge on unlit mole -> 12'h009; score 0 -> stays 0; undefined -> unchanged.
REQ-034 run dropped with moles lit -> FLUSH color=0 next cycle, IDLE following cycle, score held; rst mid-RUN -> all outputs 0.
